sample_frame_buffer: RTL and testbench

SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

---
 rtl/sample_frame_buffer_if.sv | 41 ++++
 rtl/sample_frame_buffer.sv | 142 ++++++++++++++
 tb/tb_sample_frame_buffer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_frame_buffer_if.sv
// Producer/consumer bus of the sample frame buffer.
// master: ADC strobe + samples in, consumer read/release; slave: the buffer.
interface sample_frame_buffer_if #(
  parameter int FRAME_LEN = 256
);
  localparam int AW = $clog2(FRAME_LEN);

  logic          advance;
  logic [23:0]   adc_left;
  logic [23:0]   adc_right;
  logic          frame_valid;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data;
  logic          frame_done;
  logic [15:0]   overflow_count;

  modport master (
    output advance,
    output adc_left,
    output adc_right,
    output rd_addr,
    output frame_done,
    input  frame_valid,
    input  rd_bank,
    input  rd_data,
    input  overflow_count
  );

  modport slave (
    input  advance,
    input  adc_left,
    input  adc_right,
    input  rd_addr,
    input  frame_done,
    output frame_valid,
    output rd_bank,
    output rd_data,
    output overflow_count
  );
endinterface

// File: rtl/sample_frame_buffer.sv
// Stereo->mono, decimate-by-DECIM, ping-pong frame buffer of FRAME_LEN.
// Ports: CLOCK_50, reset (sync, active-high), bus (slave side of the if).
module sample_frame_buffer #(
  parameter int FRAME_LEN = 256,
  parameter int DECIM     = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  sample_frame_buffer_if.slave bus
);
  localparam int AW    = $clog2(FRAME_LEN);
  localparam int LD    = $clog2(DECIM);
  localparam int CW    = (LD > 0) ? LD : 1;
  localparam int ACCW  = 24 + LD;
  localparam int DEPTH = 2 * FRAME_LEN;

  logic signed [24:0]     sum_lr;
  logic signed [23:0]     mono;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_d;
  logic signed [ACCW-1:0] acc_sum;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   grp_last;
  logic                   commit;
  logic [23:0]            commit_val;

  logic                   wr_bank_q;
  logic                   wr_bank_d;
  logic                   rd_bank_q;
  logic                   rd_bank_d;
  logic [AW-1:0]          wr_idx_q;
  logic [AW-1:0]          wr_idx_d;
  logic [1:0]             full_q;
  logic [1:0]             full_d;
  logic [15:0]            ovf_q;
  logic [15:0]            ovf_d;
  logic [23:0]            rd_data_q;

  logic                   wr_en;
  logic                   wr_last;
  logic                   drop;
  logic                   rel;

  logic [23:0]            mem [DEPTH];

  // 25-bit sum cannot overflow; halving brings it back into 24 bits.
  assign sum_lr = $signed({bus.adc_left[23], bus.adc_left})
                + $signed({bus.adc_right[23], bus.adc_right});
  assign mono   = 24'(sum_lr >>> 1);

  assign acc_sum    = acc_q + ACCW'(mono);
  assign commit_val = 24'(acc_sum >>> LD);
  assign grp_last   = (cnt_q == CW'(DECIM - 1));
  assign commit     = bus.advance & grp_last;

  // All decisions use pre-edge full flags, so a commit into
  // the bank being released this cycle is still dropped.
  assign wr_en   = commit & ~full_q[wr_bank_q];
  assign drop    = commit & full_q[wr_bank_q];
  assign wr_last = (wr_idx_q == AW'(FRAME_LEN - 1));
  assign rel     = bus.frame_done & full_q[rd_bank_q];

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    ovf_d     = ovf_q;

    if (bus.advance) begin
      if (grp_last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (wr_en) begin
      wr_idx_d = wr_idx_q + AW'(1);
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end

    // Cannot collide with the set above: a set needs the
    // write bank empty, a release needs the read bank full.
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      ovf_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  // Plain write port keeps the array inferable as block RAM.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      mem[{wr_bank_q, wr_idx_q}] <= commit_val;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[{rd_bank_q, bus.rd_addr}];
    end
  end

  assign bus.frame_valid    = full_q[rd_bank_q];
  assign bus.rd_bank        = rd_bank_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.overflow_count = ovf_q;
endmodule

// File: tb/tb_sample_frame_buffer.sv
// Bench for sample_frame_buffer: queue-based frame model + literal checks.
// Second instance (DECIM=1) exercises overflow_count saturation.
module tb_sample_frame_buffer;
  localparam int FL = 8;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #10 clk = ~clk;

  sample_frame_buffer_if #(.FRAME_LEN(FL)) bm ();
  sample_frame_buffer_if #(.FRAME_LEN(FL)) bs ();

  sample_frame_buffer #(.FRAME_LEN(FL), .DECIM(DC)) u_dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bm)
  );

  sample_frame_buffer #(.FRAME_LEN(FL), .DECIM(1)) u_sat (
    .CLOCK_50 (clk),
    .reset    (rst2),
    .bus      (bs)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // part: samples of the frame being filled; fq: completed frames
  // back to back, oldest first (at most two frames).
  int acc_s;
  int acc_n;
  int m_ovf;
  int part[$];
  int fq[$];
  bit m_rdb;

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int sx(input logic [23:0] v);
    return int'($signed(v));
  endfunction

  always @(posedge clk) begin : cmp
    logic        adv;
    logic        fd;
    logic        rchk;
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] erd;
    logic [2:0]  a;
    bit          fvp;
    int          s;
    adv  = bm.advance;
    fd   = bm.frame_done;
    l    = bm.adc_left;
    r    = bm.adc_right;
    a    = bm.rd_addr;
    rchk = 1'b0;
    erd  = '0;
    if (rst) begin
      acc_s = 0;
      acc_n = 0;
      m_ovf = 0;
      m_rdb = 1'b0;
      part.delete();
      fq.delete();
      rchk = 1'b1;
    end else begin
      fvp = (fq.size() > 0);
      if (fvp) begin
        rchk = 1'b1;
        erd  = 24'(fq[a]);
      end
      if (adv) begin
        acc_s += fdiv(sx(l) + sx(r), 2);
        acc_n++;
        if (acc_n == DC) begin
          s     = fdiv(acc_s, DC);
          acc_s = 0;
          acc_n = 0;
          if (fq.size() == 2 * FL) begin
            if (m_ovf < 65535) m_ovf++;
          end else begin
            part.push_back(s);
            if (part.size() == FL) begin
              foreach (part[i]) fq.push_back(part[i]);
              part.delete();
            end
          end
        end
      end
      if (fd && fvp) begin
        repeat (FL) void'(fq.pop_front());
        m_rdb = ~m_rdb;
      end
    end
    #1;
    chk("m_valid", bm.frame_valid, 32'(fq.size() > 0));
    chk("m_bank", bm.rd_bank, 32'(m_rdb));
    chk("m_ovf", bm.overflow_count, m_ovf);
    if (rchk) chk("m_rdata", bm.rd_data, erd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Random idle gap first so the advance edge is the last one.
  task automatic push(input logic [23:0] l, input logic [23:0] r);
    repeat ($urandom_range(0, 2)) tick();
    bm.advance   = 1'b1;
    bm.adc_left  = l;
    bm.adc_right = r;
    bm.rd_addr   = 3'($urandom_range(0, FL - 1));
    tick();
    bm.advance   = 1'b0;
    bm.adc_left  = 24'($urandom);
    bm.adc_right = 24'($urandom);
  endtask

  task automatic commit(input int v);
    push(24'(v), 24'(v));
    push(24'(v), 24'(v));
  endtask

  task automatic rd(input int a);
    bm.rd_addr = 3'(a);
    tick();
  endtask

  task automatic fdone();
    bm.frame_done = 1'b1;
    tick();
    bm.frame_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fv"}, bm.frame_valid, 0);
    chk({tag, "_bank"}, bm.rd_bank, 0);
    chk({tag, "_rd"}, bm.rd_data, 0);
    chk({tag, "_ovf"}, bm.overflow_count, 0);
  endtask

  task automatic main_seq();
    do_reset();
    chk_zero("rst");

    // ramp frame
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("fv_pre", bm.frame_valid, 0);
      push(24'(k * 16), 24'(k * 16));
    end
    chk("fv_rise", bm.frame_valid, 1);
    chk("ramp_bank", bm.rd_bank, 0);
    for (int i = 0; i < FL; i++) begin
      rd(i);
      chk("ramp", bm.rd_data, 32 * i + 8);
    end
    fdone();
    chk("fv_drop", bm.frame_valid, 0);

    // mono arithmetic extremes
    commit(24'h7FFFFF);
    push(24'h800000, 24'h7FFFFF);
    push(24'h800000, 24'h7FFFFF);
    commit(24'h800000);
    for (int i = 0; i < 5; i++) commit(0);
    rd(0);
    chk("mono_pp", bm.rd_data, 24'h7FFFFF);
    rd(1);
    chk("mono_np", bm.rd_data, 24'hFFFFFF);
    rd(2);
    chk("mono_nn", bm.rd_data, 24'h800000);
    fdone();

    // ping-pong overflow
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < FL; i++) commit(f * 1000 + i);
    chk("pp_ovf", bm.overflow_count, 8);
    chk("pp_bank", bm.rd_bank, 0);
    rd(3);
    chk("pp_b0", bm.rd_data, 3);
    fdone();
    chk("pp_bank1", bm.rd_bank, 1);
    chk("pp_fv", bm.frame_valid, 1);
    rd(3);
    chk("pp_b1", bm.rd_data, 1003);

    // simultaneous commit + release of the full write bank
    for (int i = 0; i < FL; i++) commit(500 + i);
    push(24'h123, 24'h123);
    bm.advance    = 1'b1;
    bm.frame_done = 1'b1;
    bm.adc_left   = 24'h123;
    bm.adc_right  = 24'h123;
    tick();
    bm.advance    = 1'b0;
    bm.frame_done = 1'b0;
    chk("sim_ovf", bm.overflow_count, 9);
    chk("sim_bank", bm.rd_bank, 0);
    for (int i = 0; i < FL; i++) commit(24'h100 + i);
    rd(0);
    chk("sim_b0", bm.rd_data, 500);
    fdone();
    rd(0);
    chk("sim_idx0", bm.rd_data, 24'h100);
    chk("sim_bank1", bm.rd_bank, 1);

    // reset mid-frame
    do_reset();
    for (int i = 0; i < 5; i++)
      push(24'($urandom), 24'($urandom));
    do_reset();
    chk_zero("mid");
    for (int k = 0; k < 16; k++) push(24'(k * 16), 24'(k * 16));
    chk("mid_fv", bm.frame_valid, 1);
    rd(0);
    chk("mid_a0", bm.rd_data, 8);
    rd(7);
    chk("mid_a7", bm.rd_data, 232);

    // random traffic, slow consumer then fast consumer
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bm.advance    = 1'($urandom_range(0, 1));
      bm.adc_left   = 24'($urandom);
      bm.adc_right  = 24'($urandom);
      bm.rd_addr    = 3'($urandom_range(0, FL - 1));
      bm.frame_done = (c < 1500) ? ($urandom_range(0, 39) == 0)
                                 : ($urandom_range(0, 5) == 0);
      tick();
    end
    bm.advance    = 1'b0;
    bm.frame_done = 1'b0;
  endtask

  task automatic sat_seq();
    tick();
    tick();
    rst2 = 1'b0;
    chk("sat_rst", bs.overflow_count, 0);
    bs.advance = 1'b1;
    for (int n = 1; n <= 16 + 70000; n++) begin
      tick();
      if (n == 16) begin
        chk("sat_full", bs.frame_valid, 1);
        chk("sat_zero", bs.overflow_count, 0);
      end
      if (n == 16 + 65534) chk("sat_fffe", bs.overflow_count, 16'hFFFE);
      if (n == 16 + 65535) chk("sat_ffff", bs.overflow_count, 16'hFFFF);
    end
    bs.advance = 1'b0;
    tick();
    chk("sat_hold", bs.overflow_count, 16'hFFFF);
  endtask

  initial begin
    rst           = 1'b1;
    rst2          = 1'b1;
    bm.advance    = 1'b0;
    bm.adc_left   = '0;
    bm.adc_right  = '0;
    bm.rd_addr    = '0;
    bm.frame_done = 1'b0;
    bs.advance    = 1'b0;
    bs.adc_left   = '0;
    bs.adc_right  = '0;
    bs.rd_addr    = '0;
    bs.frame_done = 1'b0;
    fork
      main_seq();
      sat_seq();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #(64'd1900000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
